// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: N-bit ripple adder split into STAGES registered segments with valid/ready (ports: clk, rst, in_valid/in_ready/in1/in2/cin, out_valid/out_ready/sum/cout; ovf when PIPE_ADDER_OVF_EN is defined)
module pipelined_ripple_adder #(
  parameter int N = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int W = N / STAGES;
  localparam int L = STAGES - 1;
  if (N < 1 || STAGES < 1 || STAGES > N || N % STAGES != 0) begin : g_bad
    $error("pipelined_ripple_adder: need N >= 1, 1 <= STAGES <= N, N %% STAGES == 0");
  end
  logic adv;
  logic [STAGES-1:0] v, c, pv, pc, co;
  logic [N-1:0] a [STAGES];
  logic [N-1:0] b [STAGES];
  logic [N-1:0] s [STAGES];
  logic [N-1:0] pa [STAGES];
  logic [N-1:0] pb [STAGES];
  logic [N-1:0] ps [STAGES];
  logic [N-1:0] ns [STAGES];
  assign adv = !v[L] || out_ready;
  assign pv = STAGES'({v, in_valid});
  assign pc = STAGES'({c, cin});
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [W:0] seg;
    if (k == 0) begin : g_first
      assign pa[k] = in1;
      assign pb[k] = in2;
      assign ps[k] = '0;
    end else begin : g_rest
      assign pa[k] = a[k-1];
      assign pb[k] = b[k-1];
      assign ps[k] = s[k-1];
    end
    assign seg = {1'b0, pa[k][k*W +: W]} + {1'b0, pb[k][k*W +: W]} + (W+1)'(pc[k]);
    assign co[k] = seg[W];
    assign ns[k] = (ps[k] & ~(N'({W{1'b1}}) << (k*W))) | (N'(seg[W-1:0]) << (k*W));
  end
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      c <= '0;
      for (int i = 0; i < STAGES; i++) begin
        a[i] <= '0;
        b[i] <= '0;
        s[i] <= '0;
      end
    end else if (adv) begin
      v <= pv;
      c <= co;
      for (int i = 0; i < STAGES; i++) begin
        a[i] <= pa[i];
        b[i] <= pb[i];
        s[i] <= ns[i];
      end
    end
`ifdef PIPE_ADDER_OVF_EN
  logic ovn;
  // a^b^sum at the msb recovers the carry into bit N-1
  assign ovn = pa[L][N-1] ^ pb[L][N-1] ^ ns[L][N-1] ^ co[L];
  always_ff @(posedge clk)
    ovf <= rst ? 1'b0 : adv ? ovn : ovf;
`endif
  assign in_ready = adv;
  assign out_valid = v[L];
  assign sum = s[L];
  assign cout = c[L];
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: scoreboard bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;
  localparam int N = 32;
  localparam int STAGES = 4;
  logic clk = 0, rst = 1, in_valid = 0, cin = 0, out_ready = 1;
  logic in_ready, out_valid, cout;
  logic [N-1:0] in1 = '0, in2 = '0, sum;
  logic [N+1:0] q [$];
  int n_chk = 0, n_fail = 0;
`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
`endif
  pipelined_ripple_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [N+1:0] model(input logic [N-1:0] x, y, input logic ci);
    logic [N:0] t;
    t = {1'b0, x} + {1'b0, y} + (N+1)'(ci);
    return {(x[N-1] == y[N-1]) && (t[N-1] != x[N-1]), t};
  endfunction
  task automatic step(input logic iv, input logic [N-1:0] x, y, input logic ci, input logic ordy, input logic r);
    logic [N+1:0] e;
    in_valid = iv; in1 = x; in2 = y; cin = ci; out_ready = ordy; rst = r;
    #1;
    if (!r && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e[N-1:0]));
        chk("cout", 64'(cout), 64'(e[N]));
`ifdef PIPE_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(e[N+1]));
`endif
      end
    end
    if (!r && in_valid && in_ready) q.push_back(model(x, y, ci));
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input logic ordy);
    step(0, '0, '0, 0, ordy, 0);
  endtask
  task automatic drain;
    for (int t = 0; t < 200 && q.size() > 0; t++) idle(1);
    chk("drain", 64'(q.size()), 0);
  endtask
  initial begin
    int lat;
    logic [N-1:0] x, y;
    @(negedge clk);
    step(0, '0, '0, 0, 1, 1);
    step(1, '1, '1, 1, 1, 1);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_sum", 64'(sum), 0);
    chk("rst_cout", 64'(cout), 0);
    chk("rst_ready", 64'(in_ready), 1);
    step(1, '1, '0, 1, 1, 0);
    lat = 1;
    while (!out_valid && lat < 64) begin idle(1); lat++; end
    chk("latency", 64'(lat), 64'(STAGES));
    chk("carry_sum", 64'(sum), 0);
    chk("carry_cout", 64'(cout), 1);
    drain();
    for (int i = 0; i < 8; i++) begin
      chk("stream_ready", 64'(in_ready), 1);
      step(1, N'(i * 32'h11111111), N'(32'h0F0F0F0F), i[0], 1, 0);
    end
    step(1, N'(32'h80000000), N'(32'h80000000), 0, 1, 0);
    step(1, N'(32'h7FFFFFFF), N'(32'h00000001), 0, 1, 0);
    step(1, N'(32'hFFFFFFFF), N'(32'h00000001), 0, 1, 0);
    drain();
    step(1, N'(32'h12345678), N'(32'h11111111), 0, 0, 0);
    for (int t = 0; t < 64 && !out_valid; t++) step(1, N'(t * 3 + 1), N'(t * 5 + 2), 1, 0, 0);
    for (int t = 0; t < 3; t++) begin
      chk("hold_sum", 64'(sum), 64'h23456789);
      chk("hold_ready", 64'(in_ready), 0);
      step(1, N'(32'hDEAD0000 + t), N'(32'h0000BEEF), 0, 0, 0);
    end
    drain();
    for (int i = 0; i < 3; i++) step(1, N'(32'hAAAA0000 + i), N'(32'h5555FFFF), 1, 1, 0);
    step(1, '1, '1, 1, 1, 1);
    q.delete();
    chk("mid_rst_valid", 64'(out_valid), 0);
    chk("mid_rst_sum", 64'(sum), 0);
    chk("mid_rst_cout", 64'(cout), 0);
    chk("mid_rst_ready", 64'(in_ready), 1);
    for (int t = 0; t < 4; t++) begin
      idle(1);
      chk("no_stale", 64'(out_valid), 0);
    end
    for (int i = 0; i < 400; i++) begin
      x = N'({$urandom, $urandom});
      y = N'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) x = '1;
      if ($urandom_range(0, 7) == 0) y = N'(1) << (N - 1);
      step(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 0);
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
